// File: rtl/ysyx_ifu_mem_pkg.sv
// Shared definitions for the IFU instruction-memory responder:
// FSM state encodings, LFSR seed, default base address and the LFSR step.
package ysyx_ifu_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;

   localparam logic [7:0]  LFSR_SEED    = 8'hA5;
   localparam logic [31:0] DEFAULT_BASE = 32'h2000_0000;

   // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1 (shift left, feedback into bit 0)
   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/ysyx_ifu_mem_lfsr8.sv
// 8-bit Fibonacci LFSR used to add random extra response latency.
// Steps every clock edge outside reset; reset loads the fixed seed.
module ysyx_lfsr8
   import ysyx_ifu_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] state
);

   // Advance the LFSR each edge, reload seed on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LFSR_SEED;
      end else begin
         state <= lfsr8_next(state);
      end
   end

endmodule

// File: rtl/ysyx_ifu_mem.sv
// ysyx_ifu_mem: instruction-memory responder for the IFU fetch read channel.
// Accepts a fetch in IDLE, waits a programmable latency, returns one word with
// a single-cycle ifu_rvalid pulse. A side port preloads program images.
// Optional feature macro: YSYX_IFU_MEM_RAND_DELAY_EN adds 0..7 random extra
// cycles of latency per request, drawn from an 8-bit LFSR.
module ysyx_ifu_mem
   import ysyx_ifu_mem_pkg::*;
#(
   parameter int                ADDR_W  = 32,
   parameter int                DATA_W  = 32,
   parameter int                DEPTH   = 1024,
   parameter logic [ADDR_W-1:0] BASE    = DEFAULT_BASE,
   parameter int                LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic              ifu_arvalid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_rvalid,
   output logic              ifu_rerr,
   input  logic              ld_wen,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata
);

   localparam int                IDX_W = $clog2(DEPTH);
   localparam int                CNT_W = 16;
   localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(4 * DEPTH);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

   mem_state_t        state;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  extra;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              rd_in_range;
   logic              rd_misaligned;
   logic [IDX_W-1:0]  rd_idx;
   logic              ld_in_range;
   logic [IDX_W-1:0]  ld_idx;

   // True when a byte address falls inside [BASE, BASE + 4*DEPTH)
   function automatic logic in_window(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] off;
      off = {1'b0, a - BASE};
      return (a >= BASE) && (off < SPAN);
   endfunction

   // Word index of a byte address relative to BASE
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE) >> 2);
   endfunction

`ifdef YSYX_IFU_MEM_RAND_DELAY_EN
   logic [7:0] lfsr;

   ysyx_lfsr8 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

   assign extra = CNT_W'(lfsr[2:0]);
`else
   assign extra = {CNT_W{1'b0}};
`endif

   // Range / alignment decode of the latched fetch address and the preload address
   always_comb begin
      rd_in_range   = in_window(addr_q);
      rd_misaligned = (addr_q[1:0] != 2'b00);
      rd_idx        = word_idx(addr_q);
      ld_in_range   = in_window(ld_addr);
      ld_idx        = word_idx(ld_addr);
   end

   // Preload write port; out-of-range writes are dropped, contents never reset
   always_ff @(posedge clk) begin
      if (ld_wen && ld_in_range) begin
         mem[ld_idx] <= ld_wdata;
      end
   end

   // Fetch FSM: accept, count down latency, emit one registered response pulse.
   // The array read here sees pre-write data on a same-edge preload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr_q     <= {ADDR_W{1'b0}};
         cnt        <= {CNT_W{1'b0}};
         ifu_rvalid <= 1'b0;
         ifu_rerr   <= 1'b0;
         ifu_rdata  <= {DATA_W{1'b0}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (ifu_arvalid) begin
                  addr_q <= ifu_araddr;
                  cnt    <= CNT_LOAD + extra;
                  state  <= ST_WAIT;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt == {CNT_W{1'b0}}) begin
                  ifu_rvalid <= 1'b1;
                  ifu_rerr   <= !rd_in_range || rd_misaligned;
                  ifu_rdata  <= rd_in_range ? mem[rd_idx] : {DATA_W{1'b0}};
                  state      <= ST_RESP;
               end else begin
                  cnt        <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RESP: begin
               ifu_rvalid <= 1'b0;
               ifu_rerr   <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               ifu_rvalid <= 1'b0;
               ifu_rerr   <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
